tb_scoreboard: RTL and testbench
================================

Name: tb_scoreboard

Overview:
- Multi-channel, in-order expected-vs-actual scoreboard for block-level benches. It generalises the one-shot EXPECT_* checks into a clocked checker.
- The bench pushes expected words per channel. The DUT output stream is compared against the queue head as it arrives.
- Outputs per-channel pass/fail counters, mismatch pulses, unexpected-data and timeout flags.
- Sits beside the DUT in each testbench. The bench prints verdicts from its outputs.

Parameters:
- DATA_W, 32, width of compared data words
- DEPTH, 16, expected-queue depth per channel (power of two, >=2)
- N_CH, 2, number of independent channels (>=1)
- CNT_W, 16, width of pass/fail counters (saturating)
- TIMEOUT, 1000, cycles a non-empty queue may wait for actual data before timeout (>=1)
- CMP_MASK, all ones (DATA_W bits), bits participating in comparison; 0 bits are ignored

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous clear, same effect as reset
- exp_valid  in  N_CH  expected word valid per channel
- exp_ready  out  N_CH  queue can accept (not full)
- exp_data  in  N_CH*DATA_W  expected words, channel c at [c*DATA_W +: DATA_W]
- act_valid  in  N_CH  DUT output valid (always accepted)
- act_data  in  N_CH*DATA_W  DUT output words, same packing
- pass_pulse  out  N_CH  1-cycle pulse: compare matched
- fail_pulse  out  N_CH  1-cycle pulse: compare mismatched
- pass_cnt  out  N_CH*CNT_W  match count per channel
- fail_cnt  out  N_CH*CNT_W  mismatch count per channel
- unexp_err  out  N_CH  sticky: actual arrived with empty queue
- timeout_err  out  N_CH  sticky: TIMEOUT exceeded
- idle  out  1  all queues empty

Behaviour:
- Reset or clear (either one, synchronous):
  - empties all queues and zeroes all counters;
  - clears the pulses, sticky flags and timeout counters;
  - after the cycle, exp_ready = all ones and idle = 1.
- Push:
  - A word is pushed on exp_valid[c] && exp_ready[c].
  - exp_ready[c] = !full[c], derived from occupancy only.
  - A pop in the same cycle does not unblock a push into a full queue.
- Actual with queue non-empty:
  - On act_valid[c], the head is popped and compared: (head ^ act) & CMP_MASK == 0.
  - Result appears as pass_pulse[c] or fail_pulse[c] exactly 1 cycle later (registered).
  - The matching counter updates in that same cycle. Counters saturate at 2^CNT_W-1.
- Actual with queue empty:
  - Nothing is popped; unexp_err[c] sets and fail_cnt[c] increments; no pulse is generated.
  - There is no bypass: an exp push in the same cycle is still queued, not compared.
- Simultaneous push and pop on a non-full queue: occupancy is unchanged and order is preserved.
- Pointers are log2(DEPTH) bits and wrap. Occupancy is log2(DEPTH)+1 bits.
- Per-channel FSM:
  - EMPTY -> WAIT on occupancy becoming nonzero.
  - WAIT -> EMPTY when the queue drains.
  - WAIT -> TIMED_OUT when the wait counter reaches TIMEOUT.
  - TIMED_OUT is held until reset or clear.
  - In TIMED_OUT, comparisons continue and counters still update.
- Wait counter (per channel):
  - Increments each WAIT cycle without act_valid[c].
  - Reloads to 0 on any pop.
  - Held at 0 in EMPTY.
- timeout_err[c] is asserted in the same cycle the FSM is in TIMED_OUT.
- idle is combinational: the AND of all queue-empty signals.
- Channels are fully independent; no cross-channel ordering exists.

Decomposition:
- Shared package tb_util gains:
  - typedef enum sb_state_e {SB_EMPTY, SB_WAIT, SB_TIMED_OUT};
  - typedef enum sb_verdict_e {SB_PASS, SB_FAIL, SB_UNEXP, SB_TIMEOUT};
  - localparam SB_CNT_W_DEFAULT = 16.
- One sub-module, tb_sb_channel, contains the queue, comparator, FSM, wait counter and counters for one channel.
- tb_scoreboard is a generate loop over N_CH plus the idle reduction.

Test Plan:
- In-order match: ch0 push 0xA5A5_0001..0x...0004, then act the same 4 words -> 4 pass_pulse, each 1 cycle after its act; pass_cnt[0]=4, fail_cnt[0]=0, idle=1.
- Mismatch with mask: CMP_MASK=0xFFFF_FF00; push 0x1234_5678.
  - act 0x1234_56FF -> pass.
  - act 0x1235_5678 -> fail_pulse, fail_cnt=1.
- Full and wrap: push 16 words.
  - exp_ready[0]=0; a 17th push is ignored.
  - pop 1 -> exp_ready=1; push and pop 40 more -> all pass, order intact across wrap.
- Unexpected: with empty ch1, act_valid[1] with a same-cycle exp push -> unexp_err[1]=1, fail_cnt[1]=1, queue occupancy 1.
- Timeout: TIMEOUT=10, push 1 word on ch0 with no act -> timeout_err[0] rises 10 cycles after the queue becomes non-empty. Late act still compares and sets pass_pulse.
- Reset mid-operation: 5 words queued and counters nonzero, assert rst_n=0 for one cycle -> all counters 0, flags 0, idle=1, exp_ready all ones.

Source files
------------

// File: rtl/tb_util.sv
// Shared bench-utility types: scoreboard channel states, verdict codes and default counter width.
package tb_util;

  typedef enum logic [1:0] {
    SB_EMPTY,
    SB_WAIT,
    SB_TIMED_OUT
  } sb_state_e;

  typedef enum logic [1:0] {
    SB_PASS,
    SB_FAIL,
    SB_UNEXP,
    SB_TIMEOUT
  } sb_verdict_e;

  localparam int SB_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/tb_sb_channel.sv
// One scoreboard channel: expected-word FIFO, masked comparator, wait FSM and saturating counters.
module tb_sb_channel
  import tb_util::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                CNT_W    = SB_CNT_W_DEFAULT,
  parameter int                TIMEOUT  = 1000,
  parameter logic [DATA_W-1:0] CMP_MASK = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  input  logic [DATA_W-1:0] act_data,
  output logic              pass_pulse,
  output logic              fail_pulse,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              unexp_err,
  output logic              timeout_err,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW:0] TO_LIM = (WW + 1)'(TIMEOUT);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ, occ_next;
  logic [WW-1:0]     wait_cnt;
  logic [WW:0]       wait_nxt;
  sb_state_e         state;
  sb_verdict_e       verdict;
  logic              full, push, pop, match, flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    flush     = !rst_n || clear;
    full      = (occ == (AW + 1)'(DEPTH));
    empty     = (occ == '0);
    exp_ready = !full;
    push      = exp_valid && !full;
    pop       = act_valid && !empty;
    match     = ((mem[rd_ptr] ^ act_data) & CMP_MASK) == '0;
    occ_next  = occ + (AW + 1)'(push) - (AW + 1)'(pop);
    wait_nxt  = {1'b0, wait_cnt} + (WW + 1)'(1);
    // An actual word with nothing queued is charged as a failure but never compared.
    verdict   = SB_PASS;
    if (act_valid && empty)
      verdict = SB_UNEXP;
    else if (act_valid && !match)
      verdict = SB_FAIL;
    timeout_err = (state == SB_TIMED_OUT);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      state      <= SB_EMPTY;
      wait_cnt   <= '0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      unexp_err  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      occ        <= occ_next;
      pass_pulse <= pop && (verdict == SB_PASS);
      fail_pulse <= pop && (verdict == SB_FAIL);
      if (act_valid) begin
        case (verdict)
          SB_PASS:          pass_cnt <= sat_inc(pass_cnt);
          SB_FAIL, SB_UNEXP: fail_cnt <= sat_inc(fail_cnt);
          default:          ;
        endcase
      end
      if (verdict == SB_UNEXP)
        unexp_err <= 1'b1;
      // State follows the post-update occupancy so WAIT begins the cycle the queue holds data.
      case (state)
        SB_EMPTY: begin
          wait_cnt <= '0;
          if (occ_next != '0)
            state <= SB_WAIT;
        end
        SB_WAIT: begin
          if (occ_next == '0) begin
            state    <= SB_EMPTY;
            wait_cnt <= '0;
          end else if (pop) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_nxt[WW-1:0];
            if (wait_nxt >= TO_LIM)
              state <= SB_TIMED_OUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tb_scoreboard.sv
// Multi-channel in-order scoreboard: one independent tb_sb_channel per channel plus the idle reduction.
module tb_scoreboard
  import tb_util::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                N_CH     = 2,
  parameter int                CNT_W    = SB_CNT_W_DEFAULT,
  parameter int                TIMEOUT  = 1000,
  parameter logic [DATA_W-1:0] CMP_MASK = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [N_CH-1:0]        exp_valid,
  output logic [N_CH-1:0]        exp_ready,
  input  logic [N_CH*DATA_W-1:0] exp_data,
  input  logic [N_CH-1:0]        act_valid,
  input  logic [N_CH*DATA_W-1:0] act_data,
  output logic [N_CH-1:0]        pass_pulse,
  output logic [N_CH-1:0]        fail_pulse,
  output logic [N_CH*CNT_W-1:0]  pass_cnt,
  output logic [N_CH*CNT_W-1:0]  fail_cnt,
  output logic [N_CH-1:0]        unexp_err,
  output logic [N_CH-1:0]        timeout_err,
  output logic                   idle
);

  logic [N_CH-1:0] ch_empty;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tb_sb_channel #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .CMP_MASK(CMP_MASK)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .exp_valid  (exp_valid[c]),
      .exp_ready  (exp_ready[c]),
      .exp_data   (exp_data[c*DATA_W +: DATA_W]),
      .act_valid  (act_valid[c]),
      .act_data   (act_data[c*DATA_W +: DATA_W]),
      .pass_pulse (pass_pulse[c]),
      .fail_pulse (fail_pulse[c]),
      .pass_cnt   (pass_cnt[c*CNT_W +: CNT_W]),
      .fail_cnt   (fail_cnt[c*CNT_W +: CNT_W]),
      .unexp_err  (unexp_err[c]),
      .timeout_err(timeout_err[c]),
      .empty      (ch_empty[c])
    );
  end

  assign idle = &ch_empty;

endmodule

// File: tb/tb_tb_scoreboard.sv
// Bench for tb_scoreboard: vector table, hand-written corner sequences and random traffic against a queue model.
module tb_tb_scoreboard;

  localparam int                DATA_W  = 32;
  localparam int                DEPTH   = 16;
  localparam int                N_CH    = 2;
  localparam int                CNT_W   = 4;
  localparam int                TIMEOUT = 10;
  localparam logic [DATA_W-1:0] MASK    = 32'hFFFF_FF00;
  localparam int                CMAX    = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear = 1'b0;
  logic [N_CH-1:0]        exp_valid = '0;
  logic [N_CH-1:0]        act_valid = '0;
  logic [N_CH*DATA_W-1:0] exp_data = '0;
  logic [N_CH*DATA_W-1:0] act_data = '0;
  logic [N_CH-1:0]        exp_ready, pass_pulse, fail_pulse, unexp_err, timeout_err;
  logic [N_CH*CNT_W-1:0]  pass_cnt, fail_cnt;
  logic                   idle;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tb_scoreboard #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT), .CMP_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data),
    .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .unexp_err(unexp_err), .timeout_err(timeout_err), .idle(idle)
  );

  // Reference model: a plain queue per channel plus counts and sticky flags.
  logic [DATA_W-1:0] mq [N_CH][$];
  int m_pc [N_CH];
  int m_fc [N_CH];
  int m_wait [N_CH];
  bit m_pp [N_CH];
  bit m_fp [N_CH];
  bit m_ue [N_CH];
  bit m_to [N_CH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step();
    logic [DATA_W-1:0] ed, ad, head;
    int pre;
    for (int c = 0; c < N_CH; c++) begin
      ed = exp_data[c*DATA_W +: DATA_W];
      ad = act_data[c*DATA_W +: DATA_W];
      m_pp[c] = 1'b0;
      m_fp[c] = 1'b0;
      if (!rst_n || clear) begin
        mq[c].delete();
        m_pc[c] = 0; m_fc[c] = 0; m_wait[c] = 0;
        m_ue[c] = 1'b0; m_to[c] = 1'b0;
        continue;
      end
      pre = mq[c].size();
      if (act_valid[c]) begin
        if (pre > 0) begin
          head = mq[c].pop_front();
          if (((head ^ ad) & MASK) == '0) begin
            m_pp[c] = 1'b1; m_pc[c] = sat(m_pc[c]);
          end else begin
            m_fp[c] = 1'b1; m_fc[c] = sat(m_fc[c]);
          end
          m_wait[c] = 0;
        end else begin
          m_ue[c] = 1'b1; m_fc[c] = sat(m_fc[c]);
        end
      end else if (pre > 0 && !m_to[c]) begin
        m_wait[c]++;
        if (m_wait[c] >= TIMEOUT) m_to[c] = 1'b1;
      end
      if (exp_valid[c] && pre < DEPTH) mq[c].push_back(ed);
      if (mq[c].size() == 0) m_wait[c] = 0;
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    v = '0;
    v[10] = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      v[c]     = (mq[c].size() < DEPTH);
      v[2+c]   = m_pp[c];
      v[4+c]   = m_fp[c];
      v[6+c]   = m_ue[c];
      v[8+c]   = m_to[c];
      if (mq[c].size() != 0) v[10] = 1'b0;
      v[11+c*CNT_W +: CNT_W] = CNT_W'(m_pc[c]);
      v[19+c*CNT_W +: CNT_W] = CNT_W'(m_fc[c]);
    end
    return v;
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({fail_cnt, pass_cnt, idle, timeout_err, unexp_err, fail_pulse, pass_pulse, exp_ready});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", dut_vec(), model_vec());
  endtask

  task automatic set_ch(input int c, input bit ev, input logic [DATA_W-1:0] ed,
                        input bit av, input logic [DATA_W-1:0] ad);
    exp_valid[c] = ev;
    exp_data[c*DATA_W +: DATA_W] = ed;
    act_valid[c] = av;
    act_data[c*DATA_W +: DATA_W] = ad;
  endtask

  task automatic quiet();
    exp_valid = '0;
    act_valid = '0;
  endtask

  function automatic logic [DATA_W-1:0] wd(input int i);
    return 32'hC000_0000 | (DATA_W'(i) << 8);
  endfunction

  typedef struct {
    bit ev; logic [31:0] ed; bit av; logic [31:0] ad;
    bit pp; bit fp; int pc; int fc; bit idl;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n;
    logic [DATA_W-1:0] ad;

    tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 32'h0,          1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 32'hA5A5_0002, 1'b0, 32'h0,          1'b0, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 32'hA5A5_0003, 1'b0, 32'h0,          1'b0, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 32'hA5A5_0004, 1'b0, 32'h0,          1'b0, 1'b0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1, 0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'hA5A5_0002, 1'b1, 1'b0, 2, 0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 32'hA5A5_0003, 1'b1, 1'b0, 3, 0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 32'hA5A5_0004, 1'b1, 1'b0, 4, 0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,          1'b0, 1'b0, 4, 0, 1'b1};
    tbl[9]  = '{1'b1, 32'h1234_5678, 1'b0, 32'h0,          1'b0, 1'b0, 4, 0, 1'b0};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 32'h1234_56FF, 1'b1, 1'b0, 5, 0, 1'b1};
    tbl[11] = '{1'b1, 32'h1234_5678, 1'b0, 32'h0,          1'b0, 1'b0, 5, 0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 32'h1235_5678, 1'b0, 1'b1, 5, 1, 1'b1};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 32'h0,          1'b0, 1'b0, 5, 1, 1'b1};

    tick();
    tick();
    check("reset_state", dut_vec(), 64'h403);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      set_ch(0, tbl[i].ev, tbl[i].ed, tbl[i].av, tbl[i].ad);
      tick();
      check($sformatf("tbl%0d", i),
            64'({pass_pulse[0], fail_pulse[0], pass_cnt[CNT_W-1:0], fail_cnt[CNT_W-1:0], idle}),
            64'({tbl[i].pp, tbl[i].fp, CNT_W'(tbl[i].pc), CNT_W'(tbl[i].fc), tbl[i].idl}));
    end
    quiet();

    // Fill to capacity, try an overflow push, then stream across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      set_ch(0, 1'b1, wd(i), 1'b0, '0);
      tick();
    end
    check("full_ready", 64'(exp_ready[0]), 64'(0));
    set_ch(0, 1'b1, 32'hDEAD_0000, 1'b0, '0);
    tick();
    check("full_ignored", 64'(exp_ready[0]), 64'(0));
    set_ch(0, 1'b0, '0, 1'b1, wd(0));
    tick();
    check("ready_after_pop", 64'(exp_ready[0]), 64'(1));
    for (int k = 0; k < 40; k++) begin
      set_ch(0, 1'b1, wd(DEPTH + k), 1'b1, wd(1 + k));
      tick();
      check($sformatf("wrap_pass%0d", k), 64'(pass_pulse[0]), 64'(1));
    end
    for (int k = 41; k < 56; k++) begin
      set_ch(0, 1'b0, '0, 1'b1, wd(k));
      tick();
    end
    quiet();
    check("wrap_idle", 64'(idle), 64'(1));

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    set_ch(1, 1'b1, 32'h7777_0000, 1'b1, 32'h0101_0000);
    tick();
    check("unexp", 64'({unexp_err[1], fail_cnt[2*CNT_W-1:CNT_W], pass_pulse[1], fail_pulse[1], idle}),
          64'({1'b1, CNT_W'(1), 1'b0, 1'b0, 1'b0}));
    set_ch(1, 1'b0, '0, 1'b1, 32'h7777_0000);
    tick();
    check("unexp_queued", 64'({pass_pulse[1], idle}), 64'({1'b1, 1'b1}));
    quiet();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    set_ch(0, 1'b1, 32'h5555_AA00, 1'b0, '0);
    tick();
    quiet();
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (timeout_err[0]) begin
        n = i;
        break;
      end
    end
    check("timeout_latency", 64'(n), 64'(TIMEOUT));
    set_ch(0, 1'b0, '0, 1'b1, 32'h5555_AA00);
    tick();
    check("late_act", 64'({pass_pulse[0], timeout_err[0]}), 64'({1'b1, 1'b1}));
    quiet();

    for (int i = 0; i < 5; i++) begin
      set_ch(1, 1'b1, wd(100 + i), 1'b0, '0);
      tick();
    end
    quiet();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_midop", dut_vec(), 64'h403);

    set_ch(0, 1'b1, wd(7), 1'b0, '0);
    set_ch(1, 1'b1, wd(8), 1'b1, wd(9));
    tick();
    set_ch(0, 1'b0, '0, 1'b1, wd(3));
    set_ch(1, 1'b1, wd(10), 1'b0, '0);
    tick();
    quiet();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_midop", dut_vec(), 64'h403);

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (mq[c].size() > 0 && $urandom_range(3) != 0)
          ad = mq[c][0] ^ (($urandom_range(1) == 1) ? DATA_W'($urandom_range(255)) : DATA_W'(32'h0001_0000));
        else
          ad = $urandom;
        set_ch(c, $urandom_range(99) < 55, $urandom, $urandom_range(99) < 45, ad);
      end
      clear = ($urandom_range(59) == 0);
      tick();
    end
    quiet();
    clear = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
